// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin issue arbiter.
package rr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_find_first_wrap.sv
// Two-pass priority search: first set bit at index >= base, else lowest set bit overall.
module rr_find_first_wrap #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [IDX_W-1:0] base,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic             hi_found, lo_found;
  logic [IDX_W-1:0] hi_idx, lo_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Descending scan so the last hit written is the lowest index.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data_in[i] && (i >= int'(base))) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (data_in[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    found = hi_found | lo_found;
    idx   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/rr_issue_arbiter.sv
// Round-robin arbiter with grant lock over a valid/ready handshake.
// Optional starvation override enabled by defining RR_ARB_STARVE_EN.
module rr_issue_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ      = 8,
  parameter int IDX_W        = $clog2(NUM_REQ),
  parameter int STARVE_LIMIT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               gnt_valid,
  input  logic               gnt_ready,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   base_ptr,
  output logic               starve_alarm
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] base_ptr_q, base_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             rr_found, win_found;
  logic [IDX_W-1:0] rr_idx, win_idx;

  rr_find_first_wrap #(.WIDTH(NUM_REQ), .IDX_W(IDX_W)) u_rr_search (
    .data_in (req_valid),
    .base    (base_ptr_q),
    .found   (rr_found),
    .idx     (rr_idx)
  );

`ifdef RR_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]            starving;
  logic                          st_found, override;
  logic [IDX_W-1:0]              st_idx;
  logic                          alarm_q, alarm_d;

  always_comb begin
    starving = '0;
    for (int i = 0; i < NUM_REQ; i++)
      starving[i] = req_valid[i] && (cnt_q[i] == CNT_W'(STARVE_LIMIT));
  end

  rr_find_first_wrap #(.WIDTH(NUM_REQ), .IDX_W(IDX_W)) u_starve_search (
    .data_in (starving),
    .base    ('0),
    .found   (st_found),
    .idx     (st_idx)
  );

  assign override  = (state_q == ARB_IDLE) && st_found;
  assign win_found = rr_found;
  assign win_idx   = override ? st_idx : rr_idx;

  always_comb begin
    cnt_d   = cnt_q;
    alarm_d = alarm_q | (override & gnt_valid);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] || flush)
        cnt_d[i] = '0;
      else if (req_valid[i] && (cnt_q[i] != CNT_W'(STARVE_LIMIT)))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign starve_alarm = alarm_q;
`else
  assign win_found    = rr_found;
  assign win_idx      = rr_idx;
  assign starve_alarm = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    base_ptr_d = base_ptr_q;
    lock_idx_d = lock_idx_q;
    req_ready  = '0;
    if (state_q == ARB_IDLE) begin
      gnt_idx   = win_idx;
      gnt_valid = win_found;
    end else begin
      gnt_idx   = lock_idx_q;
      gnt_valid = req_valid[lock_idx_q];
    end
    // Flush and reset both suppress the offer, which also blocks the handshake.
    if (flush || !reset_n) gnt_valid = 1'b0;
    if (gnt_valid && gnt_ready) begin
      req_ready[gnt_idx] = 1'b1;
      base_ptr_d         = IDX_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
      state_d            = ARB_IDLE;
    end else if (gnt_valid && (state_q == ARB_IDLE)) begin
      lock_idx_d = gnt_idx;
      state_d    = ARB_LOCK;
    end
    if (flush) state_d = ARB_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      base_ptr_q <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      base_ptr_q <= base_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign base_ptr   = base_ptr_q;
  assign gnt_onehot = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;

endmodule

// File: tb/tb_rr_issue_arbiter.sv
// Scoreboard bench for rr_issue_arbiter: driver queues expected per-cycle outputs, monitor checks them.
module tb_rr_issue_arbiter;

  logic       clock = 1'b0;
  logic       reset_n, flush, gnt_ready;
  logic [7:0] req_valid, req_ready, gnt_onehot;
  logic       gnt_valid, starve_alarm;
  logic [2:0] gnt_idx, base_ptr;

  typedef struct {
    logic       gv;
    logic [2:0] idx;
    logic [7:0] rr;
    logic [2:0] bp;
    logic       chk;
    logic       al;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic       pend = 1'b0;
  logic [2:0] pend_idx = '0;

  rr_issue_arbiter #(.NUM_REQ(8), .IDX_W(3), .STARVE_LIMIT(3)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .gnt_valid    (gnt_valid),
    .gnt_ready    (gnt_ready),
    .gnt_idx      (gnt_idx),
    .gnt_onehot   (gnt_onehot),
    .base_ptr     (base_ptr),
    .starve_alarm (starve_alarm)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string nm, input int unsigned act, input int unsigned want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
    end
  endfunction

  // Monitor: inputs change just after posedge, so outputs are settled at negedge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("gnt_valid", 32'(gnt_valid), 32'(e.gv));
      if (e.gv) chk("gnt_idx", 32'(gnt_idx), 32'(e.idx));
      chk("req_ready", 32'(req_ready), 32'(e.rr));
      chk("gnt_onehot", 32'(gnt_onehot), e.gv ? (32'd1 << e.idx) : 32'd0);
      if (e.chk) begin
        chk("base_ptr", 32'(base_ptr), 32'(e.bp));
        chk("starve_alarm", 32'(starve_alarm), 32'(e.al));
      end
    end
    // Requester rule: an offered but unaccepted grant must stay requested.
    if (reset_n && !flush)
      assert (!(pend && !req_valid[pend_idx])) else $error("protocol drop on req %0d", pend_idx);
    pend     = gnt_valid && !gnt_ready && reset_n && !flush;
    pend_idx = gnt_idx;
  end

  task automatic cyc(input logic [7:0] rv, input logic gr, input logic fl, input logic rn,
                     input logic gv, input logic [2:0] idx, input logic [7:0] rr,
                     input logic [2:0] bp, input logic c, input logic al);
    exp_t e;
    req_valid = rv; gnt_ready = gr; flush = fl; reset_n = rn;
    e.gv = gv; e.idx = idx; e.rr = rr; e.bp = bp; e.chk = c; e.al = al;
    exp_q.push_back(e);
    @(posedge clock); #1;
  endtask

  initial begin
    req_valid = '0; gnt_ready = 1'b0; flush = 1'b0; reset_n = 1'b0;
    @(posedge clock); #1;
    // Reset: outputs forced low; state visible from the second cycle.
    cyc(8'h00, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0);
    cyc(8'hFF, 1, 0, 0,  0, 0, 8'h00, 0, 1, 0);
`ifndef RR_ARB_STARVE_EN
    // All requesting: strict rotation 0..7 then wrap to 0.
    for (int k = 0; k < 9; k++)
      cyc(8'hFF, 1, 0, 1,  1, 3'(k % 8), 8'(1 << (k % 8)), 3'(k % 8), 1, 0);
    // Move base to 6, then search wraps to 0, then continues from 1.
    cyc(8'h20, 1, 0, 1,  1, 5, 8'h20, 1, 1, 0);
    cyc(8'h05, 1, 0, 1,  1, 0, 8'h01, 6, 1, 0);
    cyc(8'h05, 1, 0, 1,  1, 2, 8'h04, 1, 1, 0);
    // Lock on 4; a late request 1 is ignored until the handshake.
    cyc(8'h10, 0, 0, 1,  1, 4, 8'h00, 3, 1, 0);
    cyc(8'h12, 0, 0, 1,  1, 4, 8'h00, 3, 1, 0);
    cyc(8'h12, 0, 0, 1,  1, 4, 8'h00, 3, 1, 0);
    cyc(8'h12, 1, 0, 1,  1, 4, 8'h10, 3, 1, 0);
    cyc(8'h02, 1, 0, 1,  1, 1, 8'h02, 5, 1, 0);
    // Lock on 3, flush beats ready; next cycle is IDLE (1 granted, not lock slot 3).
    cyc(8'h08, 0, 0, 1,  1, 3, 8'h00, 2, 1, 0);
    cyc(8'h08, 1, 1, 1,  0, 0, 8'h00, 2, 1, 0);
    cyc(8'h02, 1, 0, 1,  1, 1, 8'h02, 2, 1, 0);
    // Reset while locked on 7; afterwards IDLE with base 0.
    cyc(8'h80, 0, 0, 1,  1, 7, 8'h00, 2, 1, 0);
    cyc(8'h80, 0, 0, 1,  1, 7, 8'h00, 2, 1, 0);
    cyc(8'h80, 1, 0, 0,  0, 0, 8'h00, 2, 1, 0);
    cyc(8'h80, 1, 0, 1,  1, 7, 8'h80, 0, 1, 0);
    cyc(8'h00, 1, 0, 1,  0, 0, 8'h00, 0, 1, 0);
    // Wrap: base 7 with only req 0 -> grant 0, base 1; idle holds base.
    cyc(8'h40, 1, 0, 1,  1, 6, 8'h40, 0, 1, 0);
    cyc(8'h01, 1, 0, 1,  1, 0, 8'h01, 7, 1, 0);
    cyc(8'h00, 1, 0, 1,  0, 0, 8'h00, 1, 1, 0);
    cyc(8'h00, 0, 0, 1,  0, 0, 8'h00, 1, 1, 0);
`else
    // Req 2 waits 3 cycles behind a lock on 0, then beats round-robin winner 1.
    cyc(8'h05, 0, 0, 1,  1, 0, 8'h00, 0, 1, 0);
    cyc(8'h05, 0, 0, 1,  1, 0, 8'h00, 0, 1, 0);
    cyc(8'h07, 1, 0, 1,  1, 0, 8'h01, 0, 1, 0);
    cyc(8'h06, 1, 0, 1,  1, 2, 8'h04, 1, 1, 0);
    cyc(8'h02, 1, 0, 1,  1, 1, 8'h02, 3, 1, 1);
    cyc(8'h00, 0, 0, 1,  0, 0, 8'h00, 2, 1, 1);
`endif
    req_valid = '0; gnt_ready = 1'b0;
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
